mux_2to1_arbiter: RTL

Two-requester round-robin arbiter that shares one downstream valid/ready channel between two upstream streams. It holds the grant for a whole packet (up to the beat carrying `last`) and steers the data path through a 2:1 select. It registers the selected beat into a single output stage. It sits in front of any single-consumer resource in the catalog that two producers must share.

---
 rtl/arb_pkg.sv | 29 ++
 rtl/mux_2to1.sv | 11 +
 rtl/mux_2to1_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the two-requester packet arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    function automatic arb_state_t arbitrate(input logic req0,
                                             input logic req1,
                                             input logic last_served);
        arb_state_t winner;
        winner = IDLE;
        if (req0 && req1) begin
            winner = last_served ? LOCK0 : LOCK1;
        end else if (req0) begin
            winner = LOCK0;
        end else if (req1) begin
            winner = LOCK1;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mux_2to1.sv
// Catalog one-bit 2:1 select cell: y = b ? d1 : d0.
module mux_2to1 (
    input  logic d0,
    input  logic d1,
    input  logic b,
    output logic y
);

    assign y = b ? d1 : d0;

endmodule

// File: rtl/mux_2to1_arbiter.sv
// Round-robin, packet-locked arbiter sharing one registered valid/ready
// output stage between two upstream streams.
module mux_2to1_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    arb_state_t state_q, state_d;
    logic       last_served_q, last_served_d;
    logic       can_load;
    logic       accept;
    logic       accept_last;
    logic [WIDTH:0] beat0, beat1, beat_sel;

    // State decodes and handshakes.
    assign sel       = (state_q == LOCK1) ? SEL_IN1 : SEL_IN0;
    assign busy      = (state_q != IDLE);
    assign can_load  = !out_valid || out_ready;
    assign in0_ready = (state_q == LOCK0) && can_load;
    assign in1_ready = (state_q == LOCK1) && can_load;
    assign accept    = (in0_valid && in0_ready) || (in1_valid && in1_ready);

    // Bit-sliced data+last select, bit WIDTH carries the last flag.
    assign beat0 = {in0_last, in0_data};
    assign beat1 = {in1_last, in1_data};

    for (genvar i = 0; i <= WIDTH; i++) begin : g_mux
        mux_2to1 u_mux (
            .d0 (beat0[i]),
            .d1 (beat1[i]),
            .b  (sel),
            .y  (beat_sel[i])
        );
    end

    assign accept_last = accept && beat_sel[WIDTH];

    // Next-state and round-robin pointer; arbitrates in IDLE and on a last-beat accept.
    always_comb begin
        logic req0, req1, do_arb;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d       = state_q;
        last_served_d = last_served_q;
        req0          = in0_valid;
        req1          = in1_valid;
        do_arb        = 1'b0;
        case (state_q)
            IDLE:  do_arb = 1'b1;
            // The releasing port's valid belongs to the beat being consumed,
            // so it is not counted as a fresh request.
            LOCK0: if (accept_last) begin do_arb = 1'b1; req0 = 1'b0; end
            LOCK1: if (accept_last) begin do_arb = 1'b1; req1 = 1'b0; end
            default: state_d = IDLE;
        endcase
        if (do_arb) begin
            state_d = arbitrate(req0, req1, last_served_q);
            if (state_d == LOCK0) last_served_d = 1'b0;
            if (state_d == LOCK1) last_served_d = 1'b1;
        end
    end

    // State register; in1 counts as last served so in0 wins the first tie.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
        end
    end

    // Single output stage: load on accept, drain when taken with nothing new.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= beat_sel[WIDTH-1:0];
            out_last  <= beat_sel[WIDTH];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
